sd_cmd_sender: RTL and testbench
================================

# sd_cmd_sender

- Sits directly upstream of the byte-level SPI engine (`spi_controller`, FRAME_WIDTH=8).
- Takes a command index and 32-bit argument, builds the 6-byte SD SPI-mode command frame and computes CRC7 over it.
- Sends the frame byte-by-byte through the engine's execute/finished handshake, polls for the R1 response, then clocks one trailing fill byte.
- Reports R1 or a timeout to the card-init and block-read sequencers above it.

## Interface

Parameters:
- RESP_TIMEOUT, 8, maximum number of response poll bytes before declaring timeout (range 1..255).

Ports:
- clk, input, 1, system clock; all logic is posedge.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, request; sampled only in IDLE.
- cmd_index, input, 6, SD command number; latched on accepted start.
- cmd_arg, input, 32, command argument; latched on accepted start.
- busy, output, 1, high from the cycle after an accepted start through the done cycle.
- done, output, 1, one-cycle completion pulse.
- r1, output, 8, received R1 byte; 8'hFF on timeout; held until the next accepted start.
- timeout, output, 1, set with done when no R1 arrived; held until the next accepted start.
- cs_n, output, 1, card chip select, active low.
- spi_execute, output, 1, one-cycle pulse requesting one byte transfer.
- spi_out_word, output, 8, byte to transmit; stable from the execute pulse until finished.
- spi_in_word, input, 8, byte received by the engine; valid when spi_finished is high.
- spi_finished, input, 1, engine's one-cycle completion strobe.

## Operation

- Reset values:
  - busy=0, done=0, timeout=0
  - r1=8'hFF
  - cs_n=1
  - spi_execute=0
  - spi_out_word=8'hFF
- Frame layout, MSB first:
  - B0 = {2'b01, cmd_index}
  - B1..B4 = cmd_arg[31:24]..[7:0]
  - B5 = {crc7, 1'b1}
- CRC7: polynomial x^7+x^3+1, init 7'h00, computed over B0..B4. The CRC is updated one byte at a time as each byte is loaded, not computed up front.
- States:
  - IDLE
    - start=1 → latch inputs, clear timeout, set r1=8'hFF, drive cs_n=0 → CMD_ISSUE.
  - CMD_ISSUE
    - Load spi_out_word with B[byte_cnt], pulse spi_execute → CMD_WAIT.
  - CMD_WAIT
    - On spi_finished: if byte_cnt==5 → POLL_ISSUE.
    - Otherwise increment byte_cnt → CMD_ISSUE.
  - POLL_ISSUE
    - spi_out_word=8'hFF, pulse spi_execute → POLL_WAIT.
  - POLL_WAIT
    - On spi_finished: if spi_in_word[7]==0 → capture r1 → TRAIL_ISSUE.
    - Else if poll_cnt==RESP_TIMEOUT-1 → set timeout → TRAIL_ISSUE.
    - Else increment poll_cnt → POLL_ISSUE.
  - TRAIL_ISSUE
    - 8'hFF, pulse spi_execute → TRAIL_WAIT.
  - TRAIL_WAIT
    - On spi_finished: cs_n=1, done=1 → IDLE.
- Counters:
  - byte_cnt is 3 bits, range 0..5.
  - poll_cnt is 8 bits.
  - Both clear on an accepted start.
- Command responses that span multiple bytes (R3/R7) are out of scope. The caller reads the remaining bytes via the raw engine after done.

## Timing

- Start acceptance: start accepted at posedge N → busy=1 and cs_n=0 from N+1. First spi_execute pulse at N+2.
- spi_execute is high for exactly one clk cycle per byte. It never re-asserts before the matching spi_finished.
- An spi_finished that arrives in the same cycle as spi_execute, or outside a *_WAIT state, is ignored.
- Next byte's execute follows finished by exactly two cycles (ISSUE state in between).
- done: asserted the cycle after the trailing byte's finished, together with cs_n=1. busy drops with done.
- A new start may be accepted in the cycle after done.
- start while busy is ignored; latched cmd_index/cmd_arg do not change.
- Reset mid-operation: all outputs return to their reset values immediately and the FSM returns to IDLE. Any in-flight engine strobe is ignored.

## Structure

Shared package `sd_pkg`:
- FSM state encodings
- SD_FILL_BYTE = 8'hFF
- SD_START_BITS = 2'b01
- CRC7_POLY = 7'h09
- Command constants CMD0, CMD8, CMD17, CMD55, CMD58, ACMD41

Sub-module `sd_crc7`:
- Combinational byte-wise next-CRC, with inputs crc_in[6:0] and data[7:0].
- Reused later by the data-token path.

## Test plan

- Frame encoding:
  - CMD0, arg 0 → MOSI bytes 40 00 00 00 00 95, then FF polls.
  - CMD8, arg 32'h000001AA → 48 00 00 01 AA 87.
  - CMD55, arg 0 → last byte 65.
  - CMD17, arg 0 → last byte 55.
- Response capture: engine model returns FF, FF, 01 on polls → r1=8'h01, timeout=0. Exactly 3 poll bytes plus 1 trail byte; done pulses once, with cs_n rising in the same cycle.
- Timeout:
  - Engine always returns FF with RESP_TIMEOUT=8 → exactly 8 poll bytes, then the trail byte.
  - Result: timeout=1, r1=8'hFF.
- Busy rejection: start pulsed during POLL_WAIT with a different cmd_index → ignored. The frame in progress and r1 are unaffected.
- Reset mid-frame: reset asserted after byte 3 → outputs at reset values in the same cycle. A subsequent CMD0 runs cleanly from B0.
- Back-to-back commands: start held high across done → second command (CMD55 then ACMD41) accepted the cycle after done, with correct CRC and counters cleared.

Source files
------------

// File: rtl/sd_pkg.sv
// Purpose: shared types and constants for the SD SPI-mode command path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, frame constants, CRC7 polynomial, common
// command indices, and a frame-byte selector used by the command sender.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_ISSUE,
        ST_CMD_WAIT,
        ST_POLL_ISSUE,
        ST_POLL_WAIT,
        ST_TRAIL_ISSUE,
        ST_TRAIL_WAIT
    } sd_state_e;

    localparam logic [7:0] SD_FILL_BYTE  = 8'hFF;
    localparam logic [1:0] SD_START_BITS = 2'b01;
    localparam logic [6:0] CRC7_POLY     = 7'h09;   // x^7 + x^3 + 1
    localparam logic [2:0] SD_LAST_BYTE  = 3'd5;    // index of the CRC byte

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] CMD58  = 6'd58;
    localparam logic [5:0] ACMD41 = 6'd41;

    // Byte idx of the 6-byte command frame, MSB first. Byte 5 carries the
    // CRC accumulated over bytes 0..4 plus the end bit.
    function automatic logic [7:0] sd_frame_byte(
        input logic [2:0]  idx,
        input logic [5:0]  cmd,
        input logic [31:0] arg,
        input logic [6:0]  crc
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = {SD_START_BITS, cmd};
            3'd1:    b = arg[31:24];
            3'd2:    b = arg[23:16];
            3'd3:    b = arg[15:8];
            3'd4:    b = arg[7:0];
            default: b = {crc, 1'b1};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Purpose: byte-wise CRC7 (x^7+x^3+1) next-state, MSB of the byte first.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: crc_in  - running CRC before this byte
//        data    - byte being folded in
//        crc_out - running CRC after this byte
module sd_crc7 (
    input  logic [6:0] crc_in,
    input  logic [7:0] data,
    output logic [6:0] crc_out
);
    import sd_pkg::*;

    logic [6:0] acc;
    logic       fb;

    always_comb begin
        acc = crc_in;
        fb  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb  = acc[6] ^ data[i];
            acc = {acc[5:0], 1'b0};
            if (fb) begin
                acc = acc ^ CRC7_POLY;
            end
        end
        crc_out = acc;
    end

endmodule

// File: rtl/sd_cmd_sender.sv
// Purpose: builds an SD SPI-mode command frame, sends it, polls for R1, clocks a fill byte.
// Latency: first spi_execute two cycles after an accepted start; done one cycle after the trail byte finishes.
// Backpressure: one byte in flight; waits on spi_finished per byte; start ignored unless idle.
// Ports: clk/reset (async active-high); start, cmd_index, cmd_arg request a command;
//        busy, done, r1, timeout report status; cs_n is the card select;
//        spi_execute/spi_out_word/spi_in_word/spi_finished drive the byte-level SPI engine.
module sd_cmd_sender #(
    parameter int RESP_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic        timeout,
    output logic        cs_n,
    output logic        spi_execute,
    output logic [7:0]  spi_out_word,
    input  logic [7:0]  spi_in_word,
    input  logic        spi_finished
);
    import sd_pkg::*;

    localparam logic [7:0] POLL_LAST = 8'(RESP_TIMEOUT - 1);

    sd_state_e   state_q, state_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic [6:0]  crc_q, crc_d, crc_next;
    logic [5:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic        busy_d, done_d, timeout_d, cs_n_d, exec_d;
    logic [7:0]  r1_d, out_d, cur_byte;
    logic        fin;

    // A strobe coinciding with our own execute pulse cannot belong to this byte.
    assign fin      = spi_finished & ~spi_execute;
    assign cur_byte = sd_frame_byte(byte_cnt_q, cmd_q, arg_q, crc_q);

    sd_crc7 u_crc7 (
        .crc_in  (crc_q),
        .data    (cur_byte),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        poll_cnt_d = poll_cnt_q;
        crc_d      = crc_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        busy_d     = busy;
        done_d     = 1'b0;
        r1_d       = r1;
        timeout_d  = timeout;
        cs_n_d     = cs_n;
        exec_d     = 1'b0;
        out_d      = spi_out_word;

        case (state_q)
            ST_IDLE: begin
                // busy stays high through the done cycle, then falls here.
                busy_d = 1'b0;
                if (start) begin
                    cmd_d      = cmd_index;
                    arg_d      = cmd_arg;
                    byte_cnt_d = 3'd0;
                    poll_cnt_d = 8'd0;
                    crc_d      = 7'd0;
                    timeout_d  = 1'b0;
                    r1_d       = SD_FILL_BYTE;
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_CMD_ISSUE;
                end
            end
            ST_CMD_ISSUE: begin
                out_d  = cur_byte;
                exec_d = 1'b1;
                // CRC accumulates as each of bytes 0..4 goes out.
                if (byte_cnt_q != SD_LAST_BYTE) begin
                    crc_d = crc_next;
                end
                state_d = ST_CMD_WAIT;
            end
            ST_CMD_WAIT: begin
                if (fin) begin
                    if (byte_cnt_q == SD_LAST_BYTE) begin
                        state_d = ST_POLL_ISSUE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        state_d    = ST_CMD_ISSUE;
                    end
                end
            end
            ST_POLL_ISSUE: begin
                out_d   = SD_FILL_BYTE;
                exec_d  = 1'b1;
                state_d = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (fin) begin
                    if (!spi_in_word[7]) begin
                        r1_d    = spi_in_word;
                        state_d = ST_TRAIL_ISSUE;
                    end else if (poll_cnt_q == POLL_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_TRAIL_ISSUE;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 8'd1;
                        state_d    = ST_POLL_ISSUE;
                    end
                end
            end
            ST_TRAIL_ISSUE: begin
                out_d   = SD_FILL_BYTE;
                exec_d  = 1'b1;
                state_d = ST_TRAIL_WAIT;
            end
            ST_TRAIL_WAIT: begin
                if (fin) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= 3'd0;
            poll_cnt_q   <= 8'd0;
            crc_q        <= 7'd0;
            cmd_q        <= 6'd0;
            arg_q        <= 32'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            r1           <= SD_FILL_BYTE;
            timeout      <= 1'b0;
            cs_n         <= 1'b1;
            spi_execute  <= 1'b0;
            spi_out_word <= SD_FILL_BYTE;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            poll_cnt_q   <= poll_cnt_d;
            crc_q        <= crc_d;
            cmd_q        <= cmd_d;
            arg_q        <= arg_d;
            busy         <= busy_d;
            done         <= done_d;
            r1           <= r1_d;
            timeout      <= timeout_d;
            cs_n         <= cs_n_d;
            spi_execute  <= exec_d;
            spi_out_word <= out_d;
        end
    end

endmodule

// File: tb/tb_sd_cmd_sender.sv
// Purpose: directed bench for sd_cmd_sender with an SPI engine model and MOSI scoreboard.
// Latency: engine model answers each execute after a programmable number of cycles.
// Backpressure: engine model accepts one byte at a time; stray executes are counted.
module tb_sd_cmd_sender;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic        busy, done, timeout, cs_n, spi_execute;
    logic [7:0]  r1, spi_out_word;
    logic [7:0]  spi_in_word;
    logic        spi_finished;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [8:0] exp_mosi[$];   // 9'h100 never matches a real byte
    logic [7:0] resp_q[$];
    int xfer_cnt  = 0;
    int fin_cnt   = 0;
    int stray_cnt = 0;
    int done_cnt  = 0;
    int eng_lat   = 2;
    bit early_strobe = 1'b0;
    logic prev_cs_n = 1'b1;

    sd_cmd_sender #(.RESP_TIMEOUT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .busy         (busy),
        .done         (done),
        .r1           (r1),
        .timeout      (timeout),
        .cs_n         (cs_n),
        .spi_execute  (spi_execute),
        .spi_out_word (spi_out_word),
        .spi_in_word  (spi_in_word),
        .spi_finished (spi_finished)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected MOSI stream and engine responses for one command.
    task automatic push_cmd(input logic [47:0] frame, input int polls, input logic [7:0] last_resp);
        for (int i = 5; i >= 0; i--) begin
            exp_mosi.push_back({1'b0, frame[i*8 +: 8]});
            resp_q.push_back(8'hFF);
        end
        for (int i = 0; i < polls; i++) begin
            exp_mosi.push_back(9'h0FF);
            resp_q.push_back((i == polls - 1) ? last_resp : 8'hFF);
        end
        exp_mosi.push_back(9'h0FF);
        resp_q.push_back(8'hFF);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},    busy,         1'b0);
        check({tag, "_done"},    done,         1'b0);
        check({tag, "_timeout"}, timeout,      1'b0);
        check({tag, "_r1"},      r1,           8'hFF);
        check({tag, "_cs_n"},    cs_n,         1'b1);
        check({tag, "_exec"},    spi_execute,  1'b0);
        check({tag, "_out"},     spi_out_word, 8'hFF);
    endtask

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg);
        @(negedge clk);
        start = 1'b1;
        cmd_index = idx;
        cmd_arg = arg;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic wait_xfer(input string tag, input int target);
        int n = 0;
        while (xfer_cnt < target && n < 1000) begin
            @(posedge clk); #2;
            n++;
        end
        check({tag, "_xfer_reached"}, (xfer_cnt >= target), 1'b1);
    endtask

    task automatic check_done_cycle(input string tag, input logic [7:0] exp_r1,
                                    input logic exp_to, input int exp_dones);
        check({tag, "_r1"},        r1,               exp_r1);
        check({tag, "_timeout"},   timeout,          exp_to);
        check({tag, "_cs_n"},      cs_n,             1'b1);
        check({tag, "_busy"},      busy,             1'b1);
        check({tag, "_bytes_left"}, exp_mosi.size(), 0);
        check({tag, "_stray"},     stray_cnt,        0);
        check({tag, "_done_cnt"},  done_cnt,         exp_dones);
    endtask

    // SPI engine model: consumes each execute, checks MOSI against the scoreboard.
    initial begin : engine
        logic [8:0] e;
        logic [7:0] r;
        spi_finished = 1'b0;
        spi_in_word  = 8'hFF;
        forever begin
            @(posedge clk); #1;
            if (spi_execute && !reset) begin
                xfer_cnt++;
                e = (exp_mosi.size() > 0) ? exp_mosi.pop_front() : 9'h100;
                r = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hFF;
                check("mosi_byte", {1'b0, spi_out_word}, e);
                if (early_strobe) begin
                    // Strobe in the execute cycle; the DUT must ignore it.
                    spi_in_word  = 8'h00;
                    spi_finished = 1'b1;
                    @(posedge clk); #1;
                    spi_finished = 1'b0;
                    spi_in_word  = 8'hFF;
                    if (spi_execute) stray_cnt++;
                end
                repeat (eng_lat) begin
                    @(posedge clk); #1;
                    if (spi_execute) stray_cnt++;
                end
                check("mosi_stable", {1'b0, spi_out_word}, e);
                spi_in_word  = r;
                spi_finished = 1'b1;
                fin_cnt++;
                @(posedge clk); #1;
                spi_finished = 1'b0;
                spi_in_word  = 8'hFF;
            end
        end
    end

    // done must be a single cycle and coincide with cs_n rising.
    initial begin : monitor
        forever begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                check("cs_rise_with_done", {prev_cs_n, cs_n}, 2'b01);
            end
            prev_cs_n = cs_n;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int base;
        // Reset state
        #1 reset = 1'b1;
        #1 check_reset_vals("rst0");
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #2;

        // CMD0 with response capture FF, FF, 01 and start timing
        push_cmd(48'h40_00_00_00_00_95, 3, 8'h01);
        issue(6'd0, 32'd0);
        check("cmd0_busy_n1", busy, 1'b1);
        check("cmd0_cs_n1",   cs_n, 1'b0);
        check("cmd0_exec_n1", spi_execute, 1'b0);
        @(posedge clk); #2;
        check("cmd0_exec_n2", spi_execute, 1'b1);
        check("cmd0_out_n2",  spi_out_word, 8'h40);
        wait_done("cmd0");
        check_done_cycle("cmd0", 8'h01, 1'b0, 1);
        @(posedge clk); #2;
        check("cmd0_busy_after", busy, 1'b0);
        check("cmd0_done_after", done, 1'b0);

        // CMD8 with strobes arriving in the execute cycle
        early_strobe = 1'b1;
        eng_lat = 1;
        push_cmd(48'h48_00_00_01_AA_87, 1, 8'h01);
        issue(6'd8, 32'h0000_01AA);
        wait_done("cmd8");
        check_done_cycle("cmd8", 8'h01, 1'b0, 2);
        early_strobe = 1'b0;

        // CMD58: card never answers, 8 polls then timeout
        eng_lat = 3;
        push_cmd(48'h7A_00_00_00_00_FD, 8, 8'hFF);
        issue(6'd58, 32'd0);
        wait_done("tmo");
        check_done_cycle("tmo", 8'hFF, 1'b1, 3);
        @(posedge clk); #2;
        check("tmo_held", timeout, 1'b1);

        // CMD17 with start pulses while busy (frame and poll phases)
        eng_lat = 2;
        push_cmd(48'h51_00_00_00_00_55, 3, 8'h00);
        base = xfer_cnt;
        issue(6'd17, 32'd0);
        check("cmd17_timeout_cleared", timeout, 1'b0);
        check("cmd17_r1_cleared", r1, 8'hFF);
        wait_xfer("rej_frame", base + 3);
        start = 1'b1; cmd_index = 6'd58; cmd_arg = 32'hFFFF_FFFF;
        @(posedge clk); #2;
        start = 1'b0;
        wait_xfer("rej_poll", base + 7);
        start = 1'b1; cmd_index = 6'd41; cmd_arg = 32'h1234_5678;
        @(posedge clk); #2;
        start = 1'b0;
        check("rej_r1_during_poll", r1, 8'hFF);
        wait_done("cmd17");
        check_done_cycle("cmd17", 8'h00, 1'b0, 4);

        // Reset after byte 3 of a frame
        push_cmd(48'h40_00_00_00_00_95, 1, 8'h01);
        base = fin_cnt;
        issue(6'd0, 32'd0);
        begin
            int n = 0;
            while (fin_cnt < base + 4 && n < 500) begin
                @(posedge clk); #2;
                n++;
            end
            check("mid_fin_reached", (fin_cnt >= base + 4), 1'b1);
        end
        @(negedge clk);
        reset = 1'b1;
        #1 check_reset_vals("rst_mid");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        exp_mosi.delete();
        resp_q.delete();
        stray_cnt = 0;
        check("rst_mid_no_done", done_cnt, 4);

        // Clean CMD0 after reset must start from byte 0
        push_cmd(48'h40_00_00_00_00_95, 2, 8'h01);
        issue(6'd0, 32'd0);
        wait_done("post_rst");
        check_done_cycle("post_rst", 8'h01, 1'b0, 5);

        // Back-to-back: CMD55 then ACMD41 with start held across done
        push_cmd(48'h77_00_00_00_00_65, 1, 8'h01);
        push_cmd(48'h69_40_00_00_00_77, 2, 8'h00);
        @(negedge clk);
        start = 1'b1; cmd_index = 6'd55; cmd_arg = 32'd0;
        @(posedge clk); #2;
        check("b2b_busy1", busy, 1'b1);
        cmd_index = 6'd41; cmd_arg = 32'h4000_0000;
        wait_done("b2b1");
        check("b2b1_r1", r1, 8'h01);
        check("b2b1_done_cnt", done_cnt, 6);
        @(posedge clk); #2;
        start = 1'b0;
        check("b2b2_busy", busy, 1'b1);
        check("b2b2_done_low", done, 1'b0);
        check("b2b2_r1_cleared", r1, 8'hFF);
        check("b2b2_cs_n", cs_n, 1'b0);
        @(posedge clk); #2;
        check("b2b2_exec", spi_execute, 1'b1);
        check("b2b2_out", spi_out_word, 8'h69);
        wait_done("b2b2");
        check_done_cycle("b2b2", 8'h00, 1'b0, 7);
        repeat (5) @(posedge clk);
        #2;
        check("final_idle_busy", busy, 1'b0);
        check("final_xfers_idle", spi_execute, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
